// File: rtl/lock_controller_fsm_if.sv
// rtl/lock_controller_fsm_if.sv - keypad/status bundle for the lock controller
interface lock_controller_fsm_if;
  logic       digit_valid_i;
  logic [3:0] digit_i;
  logic       lock_i;
  logic       set_code_i;
  logic       new_o;
  logic       open_o;
  logic       alarm_o;
  logic [2:0] tries_left_o;

  // Driver side: keypad source and status consumer
  modport master (
    output digit_valid_i, digit_i, lock_i, set_code_i,
    input  new_o, open_o, alarm_o, tries_left_o
  );

  // Controller side
  modport slave (
    input  digit_valid_i, digit_i, lock_i, set_code_i,
    output new_o, open_o, alarm_o, tries_left_o
  );
endinterface

// File: rtl/lock_controller_fsm.sv
// rtl/lock_controller_fsm.sv - combination lock sequencer: program, verify, count failures, alarm
module lock_controller_fsm #(
  parameter int CODE_LEN   = 4,
  parameter int MAX_TRIES  = 3,
  parameter int ALARM_HOLD = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  lock_controller_fsm_if.slave  bus
);

  localparam int EW = 4 * CODE_LEN;
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int TW = $clog2(ALARM_HOLD + 1);
  localparam logic [2:0]    MAX_T   = 3'(MAX_TRIES);
  localparam logic [CW-1:0] LAST    = CW'(CODE_LEN - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(ALARM_HOLD - 1);

  typedef enum logic [1:0] {S_NEW, S_LOCKED, S_OPEN, S_ALARM} state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [EW-1:0] code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    tries_q, tries_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          accept;
  logic          last_digit;
  logic [EW-1:0] entry_shift;

  // State register; reset abandons any entry or alarm in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_NEW;
      entry_q <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      tries_q <= MAX_T;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic: digit accumulation, code program/compare, alarm countdown
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    code_d      = code_q;
    cnt_d       = cnt_q;
    tries_d     = tries_q;
    timer_d     = timer_q;
    accept      = bus.digit_valid_i && (bus.digit_i <= 4'd9);
    last_digit  = (cnt_q == LAST);
    entry_shift = {entry_q[EW-5:0], bus.digit_i};

    case (state_q)
      S_NEW: begin
        if (accept) begin
          entry_d = entry_shift;
          if (last_digit) begin
            code_d  = entry_shift;
            cnt_d   = '0;
            state_d = S_LOCKED;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_LOCKED: begin
        if (accept) begin
          entry_d = entry_shift;
          if (last_digit) begin
            cnt_d = '0;
            if (entry_shift == code_q) begin
              state_d = S_OPEN;
              tries_d = MAX_T;
            end else if (tries_q <= 3'd1) begin
              state_d = S_ALARM;
              tries_d = 3'd0;
              timer_d = HOLD_LD;
            end else begin
              tries_d = tries_q - 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_OPEN: begin
        // Reprogramming keeps the old code until the new one is complete
        cnt_d = '0;
        if (bus.lock_i) begin
          state_d = S_LOCKED;
        end else if (bus.set_code_i) begin
          state_d = S_NEW;
        end
      end
      S_ALARM: begin
        if (timer_q == '0) begin
          state_d = S_LOCKED;
          tries_d = MAX_T;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_NEW;
    endcase
  end

  assign bus.new_o        = (state_q == S_NEW);
  assign bus.open_o       = (state_q == S_OPEN);
  assign bus.alarm_o      = (state_q == S_ALARM);
  assign bus.tries_left_o = tries_q;

endmodule

// File: doc/lock_controller_fsm.md
Name: lock_controller_fsm

Overview:
Sequential core of the combination lock. It accepts keypad digits, stores a user-programmed code, compares entered codes against it, and counts failed attempts. It drives the registered status levels new, open and alarm consumed directly by the downstream 7-segment status decoder. It also drives a remaining-tries count for diagnostics.

Parameters:
CODE_LEN, 4, number of decimal digits in a code (2..8)
MAX_TRIES, 3, consecutive wrong codes that trigger alarm (1..7)
ALARM_HOLD, 1000, clock cycles alarm stays asserted before auto-relock (>=1)

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high; sampled on clk rising edge
digit_valid  input  1  one-cycle strobe, digit is valid
digit  input  4  BCD keypad digit; values 10..15 are ignored
lock  input  1  one-cycle strobe, relock while open
set_code  input  1  one-cycle strobe, start reprogramming while open
new  output  1  high in NEW state (code programming)
open  output  1  high in OPEN state
alarm  output  1  high in ALARM state
tries_left  output  3  remaining attempts before alarm

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state=NEW, new=1, open=0, alarm=0, tries_left=MAX_TRIES.
  - Entry register, digit counter and alarm timer are cleared.
  - Stored code is cleared to all zeros.
- Reset asserted mid-entry or mid-alarm aborts it; reset has priority over every other input.
- Outputs are registered and decoded from state.
  - Exactly one of new/open/alarm is high, or none of them in LOCKED.
  - Outputs change on the clk edge that follows the edge on which the event is sampled, giving 1-cycle latency.
- Accepted digit: digit_valid=1 and digit<=9.
  - Each accepted digit shifts into the entry register as the new LSB nibble and increments the digit counter.
  - Invalid strobes do not change the counter or the register.
- NEW state:
  - Accepted digits build the entry.
  - On the CODE_LEN-th digit, the full entry including that digit is written to the stored code.
  - The counter clears and the next state is LOCKED. lock and set_code are ignored.
- LOCKED state:
  - Accepted digits build the entry.
  - On the CODE_LEN-th digit, the full entry is compared with the stored code and the counter clears.
  - Match: next state OPEN, tries_left=MAX_TRIES.
  - Mismatch: tries_left decrements. If it reaches 0, next state is ALARM and the timer loads ALARM_HOLD-1. Otherwise the state stays LOCKED.
  - lock and set_code are ignored.
- OPEN state:
  - Digits are ignored and the counter is held at 0.
  - lock=1 -> LOCKED.
  - set_code=1 (with lock=0) -> NEW; the old code is kept until the new one completes.
  - lock and set_code in the same cycle: lock wins.
- ALARM state:
  - All inputs except reset are ignored.
  - The timer decrements each cycle. While the timer is 0 -> LOCKED, tries_left=MAX_TRIES.
  - alarm is therefore high for exactly ALARM_HOLD cycles.
- No partial-entry timeout: a partial entry persists indefinitely until completed or reset.
- Widths:
  - Entry and stored code are 4*CODE_LEN bits.
  - Digit counter is $clog2(CODE_LEN+1) bits.
  - Timer is $clog2(ALARM_HOLD+1) bits.
  - tries_left is zero-extended to 3 bits.

Test Plan:
- Reset, then digits 1,2,3,4 -> new=1 until one cycle after the digit 4 strobe, then new=0, open=0, alarm=0 (LOCKED).
- From LOCKED with code 1234, enter 1,2,3,4 -> open=1 one cycle after the last digit, tries_left=3; then lock strobe -> open=0 next cycle.
- Enter 9,9,9,9 three times (MAX_TRIES=3) -> tries_left goes 2, then 1; alarm=1 after the third wrong code; with ALARM_HOLD=8, alarm is high exactly 8 cycles, then LOCKED with tries_left=3.
- Digit strobes with values 12, 15 interleaved among 1,2,3,4 -> ignored, and the lock still opens on 1234; digits sent while OPEN or ALARM -> no state change.
- OPEN with lock and set_code in the same cycle -> LOCKED (new stays 0); set_code alone, then 5,6,7,8 -> LOCKED, and 5678 then opens while 1234 fails.
- Reset asserted after 2 of 4 digits, or mid-alarm -> next cycle new=1, alarm=0, tries_left=3, and the stored code is zero.
